// File: rtl/bar_frame_writer.sv
// Writer side of the downscaled ping-pong frame buffer: collects one frame of bar
// heights over a valid/ready stream, then renders a bar graph into the RAM on frame_start.
module bar_frame_writer #(
   parameter int DS_WIDTH   = 32,
   parameter int DS_HEIGHT  = 24,
   parameter int ADDR_WIDTH = 10,
   parameter int MAG_WIDTH  = 5,
   parameter int RED_ROWS   = 4,
   parameter int YEL_ROWS   = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic                  bar_valid,
   output logic                  bar_ready,
   input  logic [MAG_WIDTH-1:0]  bar_height,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [7:0]            write_data,
   output logic                  write_en,
   output logic                  frame_done,
   output logic                  frame_skip
);

   localparam int X_W = $clog2(DS_WIDTH);
   localparam int Y_W = $clog2(DS_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DS_WIDTH * DS_HEIGHT - 1);
   localparam logic [MAG_WIDTH-1:0]  H_MAX     = MAG_WIDTH'(DS_HEIGHT);
   localparam logic [X_W-1:0]        X_LAST    = X_W'(DS_WIDTH - 1);
   localparam logic [Y_W-1:0]        Y_LAST    = Y_W'(DS_HEIGHT - 1);

   typedef enum logic [1:0] {LOAD, ARMED, DRAW} state_t;

   state_t                  state_q, state_d;
   logic [X_W-1:0]          bar_cnt_q, bar_cnt_d;
   logic [X_W-1:0]          x_q, x_d;
   logic [Y_W-1:0]          y_q, y_d;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [7:0]              data_d;
   logic                    wen_d, done_d, skip_d;
   logic                    store_en;
   logic                    issue;
   logic [MAG_WIDTH-1:0]    store_val;
   logic [MAG_WIDTH-1:0]    heights [DS_WIDTH];

   // Row 0 is the top of the screen, so a bar of height h lights the bottom h rows.
   function automatic logic [7:0] colour(input logic [Y_W-1:0] y, input logic [MAG_WIDTH-1:0] h);
      logic [7:0] c;
      c = 8'h00;
      if ((DS_HEIGHT - 1 - int'(y)) < int'(h)) begin
         if (int'(y) < RED_ROWS)                 c = 8'hE0;
         else if (int'(y) < RED_ROWS + YEL_ROWS) c = 8'hFC;
         else                                    c = 8'h1C;
      end
      return c;
   endfunction

   assign bar_ready = (state_q == LOAD);
   assign store_val = (bar_height > H_MAX) ? H_MAX : bar_height;

   // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      bar_cnt_d = bar_cnt_q;
      x_d       = x_q;
      y_d       = y_q;
      addr_d    = write_addr;
      data_d    = 8'h00;
      wen_d     = 1'b0;
      done_d    = 1'b0;
      skip_d    = 1'b0;
      store_en  = 1'b0;
      issue     = 1'b0;

      case (state_q)
         LOAD: begin
            skip_d = frame_start;
            if (bar_valid) begin
               store_en = 1'b1;
               if (bar_cnt_q == X_LAST) begin
                  bar_cnt_d = '0;
                  state_d   = ARMED;
               end else begin
                  bar_cnt_d = bar_cnt_q + X_W'(1);
               end
            end
         end
         ARMED: begin
            if (frame_start) begin
               state_d = DRAW;
               addr_d  = '0;
               issue   = 1'b1;
            end
         end
         DRAW: begin
            skip_d = frame_start;
            if (write_addr == LAST_ADDR) begin
               state_d = LOAD;
               done_d  = 1'b1;
               addr_d  = '0;
               x_d     = '0;
               y_d     = '0;
            end else begin
               addr_d = write_addr + ADDR_WIDTH'(1);
               issue  = 1'b1;
            end
         end
         default: state_d = LOAD;
      endcase

      // x_q/y_q always name the block for the next write, so the address counter stays multiplier-free.
      if (issue) begin
         wen_d  = 1'b1;
         data_d = colour(y_q, heights[x_q]);
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= LOAD;
         bar_cnt_q  <= '0;
         x_q        <= '0;
         y_q        <= '0;
         write_addr <= '0;
         write_data <= 8'h00;
         write_en   <= 1'b0;
         frame_done <= 1'b0;
         frame_skip <= 1'b0;
      end else begin
         state_q    <= state_d;
         bar_cnt_q  <= bar_cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         write_addr <= addr_d;
         write_data <= data_d;
         write_en   <= wen_d;
         frame_done <= done_d;
         frame_skip <= skip_d;
      end
   end

   // NOTE: the height file is small and is reset explicitly so a fresh frame never renders stale bars.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DS_WIDTH; i++) heights[i] <= '0;
      end else if (store_en) begin
         heights[bar_cnt_q] <= store_val;
      end
   end

endmodule

// File: tb/tb_bar_frame_writer.sv
// Directed bench for bar_frame_writer: loads bar frames, captures each sweep into a
// local frame image and compares it with hand-picked vectors and an independent colour model.
module tb_bar_frame_writer;

   localparam int W  = 32;
   localparam int H  = 24;
   localparam int NB = W * H;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       bar_valid = 1'b0;
   logic       bar_ready;
   logic [4:0] bar_height = 5'd0;
   logic [9:0] write_addr;
   logic [7:0] write_data;
   logic       write_en;
   logic       frame_done;
   logic       frame_skip;

   int checks = 0;
   int errors = 0;
   int hts [W];
   logic [7:0] frame [NB];

   typedef struct {
      int         addr;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [16];

   bar_frame_writer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .bar_valid   (bar_valid),
      .bar_ready   (bar_ready),
      .bar_height  (bar_height),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .write_en    (write_en),
      .frame_done  (frame_done),
      .frame_skip  (frame_skip)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_colour(input int x, input int y);
      int hh;
      hh = (hts[x] > H) ? H : hts[x];
      if (y < H - hh) return 8'h00;
      if (y < 4)      return 8'hE0;
      if (y < 10)     return 8'hFC;
      return 8'h1C;
   endfunction

   task automatic clear_frame();
      for (int i = 0; i < NB; i++) frame[i] = 8'h55;
   endtask

   task automatic check_frame(input string name);
      int bad;
      bad = 0;
      for (int a = 0; a < NB; a++)
         if (frame[a] !== exp_colour(a % W, a / W)) bad++;
      check(name, bad, 0);
   endtask

   task automatic send_bar(input logic [4:0] h, input int gap, input logic fs);
      int n;
      repeat (gap) @(negedge clk);
      bar_valid   = 1'b1;
      bar_height  = h;
      frame_start = fs;
      n = 0;
      while (!bar_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("bar_ready wait", 0, 1);
      @(negedge clk);
      bar_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic load_bars(input int first, input int last, input bit rnd, input bit fs_last);
      for (int i = first; i <= last; i++) begin
         send_bar(5'(hts[i]), rnd ? int'($urandom_range(0, 2)) : 0, fs_last && (i == last));
         if (i == W - 2) check("ready after 31 bars", bar_ready, 1);
         if (i == W - 1 && !fs_last) check("ready after 32 bars", bar_ready, 0);
      end
   endtask

   task automatic do_draw(input int start_at, input int reset_at,
                          output int nwr, output int addr_err, output int skips);
      int k;
      addr_err = 0;
      skips    = 0;
      k        = 0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("first write latency", write_en, 1);
      check("first write addr", write_addr, 0);
      while (write_en && k < 1000) begin
         if (int'(write_addr) < NB) frame[write_addr] = write_data;
         if (int'(write_addr) != k) addr_err++;
         if (k == reset_at) begin
            rst_n = 1'b0;
            #1;
            check("reset drops write_en", write_en, 0);
            check("reset raises bar_ready", bar_ready, 1);
            break;
         end
         frame_start = (k == start_at);
         @(negedge clk);
         if (frame_skip) skips++;
         k++;
      end
      frame_start = 1'b0;
      nwr = k;
   endtask

   initial begin
      int nwr, aerr, skips, stray;

      repeat (3) @(negedge clk);
      check("reset bar_ready", bar_ready, 1);
      check("reset write_addr", write_addr, 0);
      check("reset write_data", write_data, 0);
      check("reset write_en", write_en, 0);
      check("reset frame_done", frame_done, 0);
      check("reset frame_skip", frame_skip, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Frame 1: all bars zero, whole buffer black.
      for (int i = 0; i < W; i++) hts[i] = 0;
      load_bars(0, W - 1, 1'b0, 1'b0);
      clear_frame();
      do_draw(-1, -1, nwr, aerr, skips);
      check("zero frame write count", nwr, NB);
      check("zero frame addr order", aerr, 0);
      check("zero frame done pulse", frame_done, 1);
      @(negedge clk);
      check("zero frame done single", frame_done, 0);
      check("zero frame idle write_en", write_en, 0);
      check("zero frame back to LOAD", bar_ready, 1);
      check("zero frame addr wrap", write_addr, 0);
      check_frame("zero frame image");

      // Frame 2: heights x mod 25 with column 3 saturating from 31.
      for (int i = 0; i < W; i++) hts[i] = i % 25;
      hts[3] = 31;
      load_bars(0, W - 1, 1'b1, 1'b0);
      clear_frame();
      do_draw(-1, -1, nwr, aerr, skips);
      check("bars frame write count", nwr, NB);
      check("bars frame addr order", aerr, 0);
      check("bars frame done pulse", frame_done, 1);

      vecs[0]  = '{24,           8'hE0};
      vecs[1]  = '{24 + 5 * 32,  8'hFC};
      vecs[2]  = '{24 + 23 * 32, 8'h1C};
      vecs[3]  = '{1 + 23 * 32,  8'h1C};
      vecs[4]  = '{1 + 22 * 32,  8'h00};
      vecs[5]  = '{1,            8'h00};
      vecs[6]  = '{3,            8'hE0};
      vecs[7]  = '{3 + 9 * 32,   8'hFC};
      vecs[8]  = '{3 + 10 * 32,  8'h1C};
      vecs[9]  = '{0 + 23 * 32,  8'h00};
      vecs[10] = '{10 + 13 * 32, 8'h00};
      vecs[11] = '{10 + 14 * 32, 8'h1C};
      vecs[12] = '{25 + 23 * 32, 8'h00};
      vecs[13] = '{31 + 17 * 32, 8'h00};
      vecs[14] = '{31 + 18 * 32, 8'h1C};
      vecs[15] = '{20 + 4 * 32,  8'hFC};
      for (int v = 0; v < 16; v++)
         check($sformatf("vector addr %0d", vecs[v].addr), frame[vecs[v].addr], vecs[v].exp);
      check_frame("bars frame image");
      @(negedge clk);

      // Early frame_start with 10 bars loaded, then final bar coinciding with frame_start.
      for (int i = 0; i < W; i++) hts[i] = (i * 7) % 32;
      load_bars(0, 9, 1'b1, 1'b0);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("early start skip", frame_skip, 1);
      check("early start no write", write_en, 0);
      check("early start stays LOAD", bar_ready, 1);
      @(negedge clk);
      check("early skip single", frame_skip, 0);
      stray = 0;
      repeat (4) begin
         @(negedge clk);
         if (write_en) stray++;
      end
      check("early start no writes", stray, 0);
      load_bars(10, W - 1, 1'b1, 1'b1);
      check("last bar + start skip", frame_skip, 1);
      check("last bar + start ARMED", bar_ready, 0);
      stray = 0;
      repeat (5) begin
         @(negedge clk);
         if (write_en) stray++;
      end
      check("armed waits for start", stray, 0);
      clear_frame();
      do_draw(-1, -1, nwr, aerr, skips);
      check("resumed frame write count", nwr, NB);
      check("resumed frame done", frame_done, 1);
      check_frame("resumed frame image");
      @(negedge clk);

      // frame_start in the middle of a sweep.
      load_bars(0, W - 1, 1'b0, 1'b0);
      clear_frame();
      do_draw(100, -1, nwr, aerr, skips);
      check("mid start skip count", skips, 1);
      check("mid start write count", nwr, NB);
      check("mid start addr order", aerr, 0);
      check("mid start done", frame_done, 1);
      check_frame("mid start image");
      @(negedge clk);

      // Reset at write 400, then a clean reload and sweep.
      load_bars(0, W - 1, 1'b0, 1'b0);
      do_draw(-1, 400, nwr, aerr, skips);
      check("reset draw reached 400", nwr, 400);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post reset write_en", write_en, 0);
      check("post reset write_addr", write_addr, 0);
      check("post reset bar_ready", bar_ready, 1);
      load_bars(0, W - 1, 1'b0, 1'b0);
      clear_frame();
      do_draw(-1, -1, nwr, aerr, skips);
      check("post reset write count", nwr, NB);
      check("post reset done", frame_done, 1);
      check_frame("post reset image");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bar_frame_writer.md
Name: bar_frame_writer

Overview:
- Writer side of the downscaled ping-pong frame buffer. The VGA scan-out path is the reader.
- Accepts one frame of spectrum bar heights from the audio analysis path over a valid/ready stream.
- On the next buffer-swap pulse, sweeps every block address of the DS_WIDTH x DS_HEIGHT buffer, writing one 3:3:2 colour byte per cycle to render a bar graph.
- Drives the write_addr / write_data / write_en port of the ping-pong RAM directly, in place of the static graphics generator.

Parameters:
- DS_WIDTH, 32, downscaled columns; one bar per column.
- DS_HEIGHT, 24, downscaled rows.
- ADDR_WIDTH, 10, RAM address width; equals $clog2(DS_WIDTH*DS_HEIGHT).
- MAG_WIDTH, 5, bar height input width.
- RED_ROWS, 4, number of top rows coloured red.
- YEL_ROWS, 6, number of rows below the red band coloured yellow.

Ports:
- clk  in  1  pixel clock, same clock as the ping-pong RAM.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse marking the buffer swap / start of vertical blanking.
- bar_valid  in  1  bar_height is valid.
- bar_ready  out  1  block accepts a bar this cycle.
- bar_height  in  MAG_WIDTH  height of the next bar, in blocks.
- write_addr  out  ADDR_WIDTH  RAM write address, row-major: y*DS_WIDTH + x.
- write_data  out  8  colour, RRRGGGBB.
- write_en  out  1  RAM write strobe.
- frame_done  out  1  one-cycle pulse after the last address is written.
- frame_skip  out  1  one-cycle pulse when frame_start arrives while not ARMED.

Behaviour:
- Reset (async assert, sync release): state=LOAD, bar_cnt=0, all heights=0. Outputs: bar_ready=1, write_addr=0, write_data=0, write_en=0, frame_done=0, frame_skip=0.
- Bar storage: register file of DS_WIDTH x MAG_WIDTH entries. Bars are indexed implicitly by arrival order, column 0 first.
- A handshake occurs when bar_valid && bar_ready. The entry at bar_cnt is stored, saturated to DS_HEIGHT (any value > DS_HEIGHT is stored as DS_HEIGHT). bar_cnt then increments.
- LOAD:
  - bar_ready=1.
  - The handshake that stores column DS_WIDTH-1 moves to ARMED next cycle and clears bar_cnt.
  - frame_start in LOAD: pulse frame_skip the next cycle, stay in LOAD, keep partial data.
- ARMED:
  - bar_ready=0.
  - frame_start: go to DRAW with x=0, y=0.
- DRAW:
  - bar_ready=0.
  - Each cycle: write_en=1, write_addr=y*DS_WIDTH+x, write_data=colour(x,y). All outputs are registered; the first write appears the cycle after frame_start is sampled.
  - x increments each cycle; when x wraps at DS_WIDTH-1, y increments.
  - Exactly DS_WIDTH*DS_HEIGHT consecutive write_en cycles (768 with defaults), with no gaps.
  - After the write to the last address (767): write_en=0 and frame_done=1 for one cycle, then state=LOAD.
  - frame_start during DRAW: ignored, and frame_skip pulses.
- Colour rule:
  - Block (x,y) is lit iff (DS_HEIGHT-1-y) < height[x]. Height 0 means the column is all black; height DS_HEIGHT means the column is fully lit.
  - Lit blocks: y < RED_ROWS gives 8'hE0; y < RED_ROWS+YEL_ROWS gives 8'hFC; otherwise 8'h1C. Unlit blocks give 8'h00.
- Address arithmetic: write_addr is held in a separate counter incremented alongside x/y, not computed with a multiplier. The counter wraps to 0 on return to LOAD.
- Reset mid-DRAW: write_en drops immediately (async). The buffer keeps whatever was partially written; the ping-pong logic owns buffer consistency.
- frame_start and the final bar handshake in the same LOAD cycle: the bar is stored, frame_skip pulses, and the block then waits in ARMED for the next frame_start.

Test Plan:
- Reset, then feed 32 bars all of height 0, then pulse frame_start -> 768 consecutive writes, addr 0..767, data all 8'h00, then frame_done pulses once.
- Feed heights x mod 25, with bar_valid toggled randomly -> bar_ready drops after the 32nd handshake. Column 24 is fully lit: addr 24 (y=0) = 8'hE0, addr 24+5*32 (y=5) = 8'hFC, addr 24+23*32 = 8'h1C. Column 1: only addr 1+23*32 = 8'h1C, all other rows 8'h00.
- Bar height 31 on column 3 -> rendered identically to height 24; addr 3 = 8'hE0.
- frame_start after only 10 bars loaded -> frame_skip=1 for one cycle, no write_en. Load 22 more bars plus a frame_start -> a normal 768-cycle draw.
- frame_start pulsed at write 100 of a DRAW -> frame_skip pulses, the sweep continues uninterrupted to addr 767.
- rst_n asserted at write 400 -> write_en=0 and bar_ready=1 in the same cycle. After release, the block is in LOAD with bar_cnt=0.
